// File: rtl/converter_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : converter_controller_if                                         |
// | Purpose  : Request/response handshake bundle of converter_controller.      |
// |            master = upstream requester, slave = controller.                |
// | Signals  : req_valid/req_ready/req_op      request handshake + opcode      |
// |            rsp_valid/rsp_ready             response handshake              |
// |            rsp_op/rsp_err                  response opcode and error flag  |
// |            rsp_bin/rsp_gray  [WIDTH]       latched binary/Gray views       |
// |            rsp_bcd/rsp_ex3   [DIGITS*4]    latched BCD/Excess-3 views      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface converter_controller_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_op;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [2:0]            rsp_op;
   logic                  rsp_err;
   logic [WIDTH-1:0]      rsp_bin;
   logic [WIDTH-1:0]      rsp_gray;
   logic [DIGITS*4-1:0]   rsp_bcd;
   logic [DIGITS*4-1:0]   rsp_ex3;

   modport master (
      output req_valid, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_op, rsp_err,
             rsp_bin, rsp_gray, rsp_bcd, rsp_ex3
   );

   modport slave (
      input  req_valid, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_op, rsp_err,
             rsp_bin, rsp_gray, rsp_bcd, rsp_ex3
   );
endinterface
`default_nettype wire

// File: rtl/converter_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : converter_controller                                            |
// | Purpose  : Sequencing FSM in front of converter_datapath. Accepts one      |
// |            opcode per request handshake, launches the selected engine,     |
// |            waits for done_any, and holds the captured result views until   |
// |            the response handshake. One transaction in flight.             |
// | Ports    : clk, rst (sync, active-high)                                    |
// |            req_rsp        converter_controller_if.slave (req/rsp bundle)   |
// |            op             registered opcode to datapath                    |
// |            start_bin2bcd  1-cycle start, op 2                              |
// |            start_bcd2bin  1-cycle start, op 3                              |
// |            busy_any       datapath busy (status only)                      |
// |            done_any       datapath done for selected op                    |
// |            *_out_comb     datapath result views                            |
// |            ctl_busy       controller not idle                              |
// | Options  : CONV_TIMEOUT_EN - abort WAIT after TIMEOUT_CYCLES with rsp_err  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module converter_controller #(
   parameter int WIDTH          = 8,
   parameter int DIGITS         = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   converter_controller_if.slave req_rsp,
   output logic [2:0]            op,
   output logic                  start_bin2bcd,
   output logic                  start_bcd2bin,
   input  logic                  busy_any,
   input  logic                  done_any,
   input  logic [WIDTH-1:0]      bin_out_comb,
   input  logic [WIDTH-1:0]      gray_out_comb,
   input  logic [DIGITS*4-1:0]   bcd_out_comb,
   input  logic [DIGITS*4-1:0]   ex3_out_comb,
   output logic                  ctl_busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [2:0] OP_BIN2BCD = 3'd2;
   localparam logic [2:0] OP_BCD2BIN = 3'd3;
   localparam logic [2:0] OP_MAX     = 3'd5;

   state_t                state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic                  start_b2d_q, start_b2d_d;
   logic                  start_d2b_q, start_d2b_d;
   logic [2:0]            rsp_op_q, rsp_op_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0]      rsp_bin_q, rsp_bin_d;
   logic [WIDTH-1:0]      rsp_gray_q, rsp_gray_d;
   logic [DIGITS*4-1:0]   rsp_bcd_q, rsp_bcd_d;
   logic [DIGITS*4-1:0]   rsp_ex3_q, rsp_ex3_d;

   // Engine busy is status only; sequencing relies solely on done_any.
   logic unused_busy;
   assign unused_busy = busy_any;

`ifdef CONV_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]           tmo_cnt_q, tmo_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      start_b2d_d = 1'b0;
      start_d2b_d = 1'b0;
      rsp_op_d    = rsp_op_q;
      rsp_err_d   = rsp_err_q;
      rsp_bin_d   = rsp_bin_q;
      rsp_gray_d  = rsp_gray_q;
      rsp_bcd_d   = rsp_bcd_q;
      rsp_ex3_d   = rsp_ex3_q;
`ifdef CONV_TIMEOUT_EN
      tmo_cnt_d   = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_rsp.req_valid) begin
               op_d     = req_rsp.req_op;
               rsp_op_d = req_rsp.req_op;
               if (req_rsp.req_op <= OP_MAX) begin
                  // Starts are registered so they line up with the LAUNCH cycle.
                  start_b2d_d = (req_rsp.req_op == OP_BIN2BCD);
                  start_d2b_d = (req_rsp.req_op == OP_BCD2BIN);
                  state_d     = S_LAUNCH;
               end else begin
                  rsp_err_d  = 1'b1;
                  rsp_bin_d  = '0;
                  rsp_gray_d = '0;
                  rsp_bcd_d  = '0;
                  rsp_ex3_d  = '0;
                  state_d    = S_RESP;
               end
            end
         end
         // done_any may still reflect a previous op here, so it is not sampled.
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            if (done_any) begin
               rsp_err_d  = 1'b0;
               rsp_bin_d  = bin_out_comb;
               rsp_gray_d = gray_out_comb;
               rsp_bcd_d  = bcd_out_comb;
               rsp_ex3_d  = ex3_out_comb;
               state_d    = S_RESP;
            end
`ifdef CONV_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               // Abort after TIMEOUT_CYCLES WAIT cycles; engine keeps running.
               rsp_err_d  = 1'b1;
               rsp_bin_d  = '0;
               rsp_gray_d = '0;
               rsp_bcd_d  = '0;
               rsp_ex3_d  = '0;
               state_d    = S_RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
`endif
         end
         S_RESP: begin
            if (req_rsp.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         start_b2d_q <= 1'b0;
         start_d2b_q <= 1'b0;
         rsp_op_q    <= '0;
         rsp_err_q   <= 1'b0;
         rsp_bin_q   <= '0;
         rsp_gray_q  <= '0;
         rsp_bcd_q   <= '0;
         rsp_ex3_q   <= '0;
`ifdef CONV_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         start_b2d_q <= start_b2d_d;
         start_d2b_q <= start_d2b_d;
         rsp_op_q    <= rsp_op_d;
         rsp_err_q   <= rsp_err_d;
         rsp_bin_q   <= rsp_bin_d;
         rsp_gray_q  <= rsp_gray_d;
         rsp_bcd_q   <= rsp_bcd_d;
         rsp_ex3_q   <= rsp_ex3_d;
`ifdef CONV_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign op                = op_q;
   assign start_bin2bcd     = start_b2d_q;
   assign start_bcd2bin     = start_d2b_q;
   assign ctl_busy          = (state_q != S_IDLE);
   assign req_rsp.req_ready = (state_q == S_IDLE);
   assign req_rsp.rsp_valid = (state_q == S_RESP);
   assign req_rsp.rsp_op    = rsp_op_q;
   assign req_rsp.rsp_err   = rsp_err_q;
   assign req_rsp.rsp_bin   = rsp_bin_q;
   assign req_rsp.rsp_gray  = rsp_gray_q;
   assign req_rsp.rsp_bcd   = rsp_bcd_q;
   assign req_rsp.rsp_ex3   = rsp_ex3_q;

endmodule
`default_nettype wire

// File: tb/tb_converter_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_converter_controller                                         |
// | Purpose  : Directed self-checking bench for converter_controller with a    |
// |            small behavioural stand-in for converter_datapath.             |
// |            Timing: accept edge T; a comb-op response is first sampled     |
// |            high after edge T+2 (high at edge T+3); illegal op after T.    |
// | Options  : CONV_TIMEOUT_EN selects the timeout scenario (TIMEOUT_CYCLES=4) |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_converter_controller;
   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;
   localparam int TMO    = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   converter_controller_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   logic [2:0]  op;
   logic        start_bin2bcd, start_bcd2bin, busy_any, done_any, ctl_busy;
   logic [7:0]  bin_out_comb, gray_out_comb;
   logic [11:0] bcd_out_comb, ex3_out_comb;

   converter_controller #(.WIDTH(WIDTH), .DIGITS(DIGITS), .TIMEOUT_CYCLES(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_rsp       (bus),
      .op            (op),
      .start_bin2bcd (start_bin2bcd),
      .start_bcd2bin (start_bcd2bin),
      .busy_any      (busy_any),
      .done_any      (done_any),
      .bin_out_comb  (bin_out_comb),
      .gray_out_comb (gray_out_comb),
      .bcd_out_comb  (bcd_out_comb),
      .ex3_out_comb  (ex3_out_comb),
      .ctl_busy      (ctl_busy)
   );

   // ---------------- datapath stand-in ----------------
   logic [7:0]  bin_in, gray_in;
   logic [11:0] bcd_in;
   logic        force_done_low;
   logic        eng_busy, eng_done;
   logic [2:0]  eng_cnt;
   logic [7:0]  eng_bin;
   logic [11:0] eng_bcd;

   function automatic logic [11:0] to_bcd(input logic [7:0] b);
      int v;
      v = int'(b);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] from_bcd(input logic [11:0] d);
      return 8'(int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]));
   endfunction

   function automatic logic [7:0] gray2bin(input logic [7:0] g);
      logic [7:0] r;
      r[7] = g[7];
      for (int i = 6; i >= 0; i--) r[i] = r[i+1] ^ g[i];
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         eng_busy <= 1'b0; eng_done <= 1'b0; eng_cnt <= '0;
         eng_bin  <= '0;   eng_bcd  <= '0;
      end else if (start_bin2bcd || start_bcd2bin) begin
         eng_busy <= 1'b1; eng_done <= 1'b0; eng_cnt <= 3'd4;
         if (start_bin2bcd) eng_bcd <= to_bcd(bin_in);
         else               eng_bin <= from_bcd(bcd_in);
      end else if (eng_busy) begin
         eng_cnt <= eng_cnt - 3'd1;
         if (eng_cnt == 3'd1) begin
            eng_busy <= 1'b0;
            eng_done <= 1'b1;
         end
      end
   end

   assign busy_any      = eng_busy;
   assign done_any      = force_done_low ? 1'b0 :
                          ((op == 3'd2 || op == 3'd3) ? eng_done : 1'b1);
   assign gray_out_comb = bin_in ^ (bin_in >> 1);
   assign bin_out_comb  = (op == 3'd3) ? eng_bin : ((op == 3'd1) ? gray2bin(gray_in) : bin_in);
   assign bcd_out_comb  = (op == 3'd2) ? eng_bcd : bcd_in;
   assign ex3_out_comb  = {bcd_in[11:8] + 4'd3, bcd_in[7:4] + 4'd3, bcd_in[3:0] + 4'd3};

   // start pulse counters
   int n_b2d = 0;
   int n_d2b = 0;
   always @(posedge clk) begin
      if (start_bin2bcd) n_b2d <= n_b2d + 1;
      if (start_bcd2bin) n_d2b <= n_d2b + 1;
   end

   int checks   = 0;
   int failures = 0;

   // ---------------- helpers (stimulus only) ----------------
   // Presents an opcode, lets the accept edge pass, drops req_valid.
   task automatic do_accept(input logic [2:0] o);
      bus.req_valid = 1'b1;
      bus.req_op    = o;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // Edges after the accept edge until rsp_valid is seen (bounded).
   task automatic wait_rsp(input int max, output int n);
      n = 0;
      while (!bus.rsp_valid && n < max) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || ctl_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_hs got valid=%b ready=%b busy=%b exp 0 1 0",
                  bus.rsp_valid, bus.req_ready, ctl_busy);
      end
      checks++;
      if (op !== 3'd0 || start_bin2bcd !== 1'b0 || start_bcd2bin !== 1'b0) begin
         failures++;
         $display("FAIL reset_op got op=%0d s=%b%b exp 0 00", op, start_bin2bcd, start_bcd2bin);
      end
      checks++;
      if (bus.rsp_err !== 1'b0 || bus.rsp_op !== 3'd0 || bus.rsp_bin !== 8'h0 ||
          bus.rsp_gray !== 8'h0 || bus.rsp_bcd !== 12'h0 || bus.rsp_ex3 !== 12'h0) begin
         failures++;
         $display("FAIL reset_rsp got err=%b op=%0d bin=%h gray=%h bcd=%h ex3=%h exp all 0",
                  bus.rsp_err, bus.rsp_op, bus.rsp_bin, bus.rsp_gray, bus.rsp_bcd, bus.rsp_ex3);
      end
   endtask

   task automatic test_bin2gray();
      int n;
      bin_in = 8'hB4;
      do_accept(3'd0);
      wait_rsp(20, n);
      checks++;
      if (n !== 2) begin failures++; $display("FAIL t1_latency got=%0d exp=2", n); end
      checks++;
      if (bus.rsp_gray !== 8'hEE || bus.rsp_err !== 1'b0 || bus.rsp_op !== 3'd0) begin
         failures++;
         $display("FAIL t1_gray got gray=%h err=%b op=%0d exp EE 0 0",
                  bus.rsp_gray, bus.rsp_err, bus.rsp_op);
      end
      bus.rsp_ready = 1'b1; #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         failures++; $display("FAIL t1_ready_in_resp got=%b exp=0", bus.req_ready);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL t1_release got valid=%b ready=%b exp 0 1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_bin2bcd();
      int n, b0, d0;
      b0 = n_b2d; d0 = n_d2b;
      bin_in = 8'd255;
      do_accept(3'd2);
      // A request held during the transaction must be ignored.
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd3;
      wait_rsp(20, n);
      checks++;
      if (n !== 6) begin failures++; $display("FAIL t2_latency got=%0d exp=6", n); end
      checks++;
      if (n_b2d - b0 !== 1 || n_d2b - d0 !== 0) begin
         failures++;
         $display("FAIL t2_pulses got b2d=%0d d2b=%0d exp 1 0", n_b2d - b0, n_d2b - d0);
      end
      checks++;
      if (bus.rsp_bcd !== 12'h255 || bus.rsp_op !== 3'd2 || bus.rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL t2_bcd got bcd=%h op=%0d err=%b exp 255 2 0",
                  bus.rsp_bcd, bus.rsp_op, bus.rsp_err);
      end
      bus.req_valid = 1'b0;
      release_rsp();
   endtask

   task automatic test_bcd2bin_hold();
      int n;
      logic [7:0] g0;
      bcd_in = 12'h128;
      do_accept(3'd3);
      wait_rsp(20, n);
      checks++;
      if (n !== 6) begin failures++; $display("FAIL t3_latency got=%0d exp=6", n); end
      g0 = bus.rsp_gray;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_bin !== 8'd128 || bus.rsp_op !== 3'd3 ||
             bus.rsp_gray !== g0) begin
            failures++;
            $display("FAIL t3_hold cyc=%0d got valid=%b bin=%0d op=%0d exp 1 128 3",
                     i, bus.rsp_valid, bus.rsp_bin, bus.rsp_op);
         end
         @(posedge clk); #1;
      end
      release_rsp();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++; $display("FAIL t3_release got=%b exp=0", bus.rsp_valid);
      end
   endtask

   task automatic test_illegal();
      int n, b0, d0;
      b0 = n_b2d; d0 = n_d2b;
      bin_in = 8'h5A; bcd_in = 12'h321;
      do_accept(3'd6);
      wait_rsp(20, n);
      checks++;
      if (n !== 0) begin failures++; $display("FAIL t4_latency got=%0d exp=0", n); end
      checks++;
      if (bus.rsp_err !== 1'b1 || bus.rsp_op !== 3'd6 || bus.rsp_bin !== 8'h0 ||
          bus.rsp_gray !== 8'h0 || bus.rsp_bcd !== 12'h0 || bus.rsp_ex3 !== 12'h0) begin
         failures++;
         $display("FAIL t4_err got err=%b op=%0d bin=%h gray=%h bcd=%h ex3=%h exp 1 6 0 0 0 0",
                  bus.rsp_err, bus.rsp_op, bus.rsp_bin, bus.rsp_gray, bus.rsp_bcd, bus.rsp_ex3);
      end
      repeat (2) @(posedge clk); #1;
      checks++;
      if (n_b2d - b0 !== 0 || n_d2b - d0 !== 0) begin
         failures++;
         $display("FAIL t4_pulses got b2d=%0d d2b=%0d exp 0 0", n_b2d - b0, n_d2b - d0);
      end
      release_rsp();
   endtask

   task automatic test_reset_abort();
      int n;
      bin_in = 8'd99;
      do_accept(3'd2);
      repeat (2) @(posedge clk); #1;   // now in WAIT
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || ctl_busy !== 1'b0) begin
         failures++;
         $display("FAIL t5_abort got valid=%b ready=%b busy=%b exp 0 1 0",
                  bus.rsp_valid, bus.req_ready, ctl_busy);
      end
      bcd_in = 12'h029;
      do_accept(3'd4);
      wait_rsp(20, n);
      checks++;
      if (n !== 2) begin failures++; $display("FAIL t5_latency got=%0d exp=2", n); end
      checks++;
      if (bus.rsp_ex3 !== 12'h35C || bus.rsp_err !== 1'b0 || bus.rsp_op !== 3'd4) begin
         failures++;
         $display("FAIL t5_ex3 got ex3=%h err=%b op=%0d exp 35C 0 4",
                  bus.rsp_ex3, bus.rsp_err, bus.rsp_op);
      end
      release_rsp();
   endtask

`ifdef CONV_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      bin_in = 8'hB4;
      force_done_low = 1'b1;
      do_accept(3'd0);
      wait_rsp(20, n);
      checks++;
      // LAUNCH takes 1 edge, then 4 WAIT cycles before the abort.
      if (n !== 5) begin failures++; $display("FAIL t6_latency got=%0d exp=5", n); end
      checks++;
      if (bus.rsp_err !== 1'b1 || bus.rsp_gray !== 8'h0 || bus.rsp_bin !== 8'h0) begin
         failures++;
         $display("FAIL t6_err got err=%b gray=%h bin=%h exp 1 00 00",
                  bus.rsp_err, bus.rsp_gray, bus.rsp_bin);
      end
      force_done_low = 1'b0;
      release_rsp();
   endtask
`else
   task automatic test_no_timeout();
      int n;
      bin_in = 8'hB4;
      force_done_low = 1'b1;
      do_accept(3'd0);
      wait_rsp(30, n);
      checks++;
      if (bus.rsp_valid !== 1'b0 || ctl_busy !== 1'b1) begin
         failures++;
         $display("FAIL t6_wait got valid=%b busy=%b exp 0 1", bus.rsp_valid, ctl_busy);
      end
      force_done_low = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_gray !== 8'hEE || bus.rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL t6_done got valid=%b gray=%h err=%b exp 1 EE 0",
                  bus.rsp_valid, bus.rsp_gray, bus.rsp_err);
      end
      release_rsp();
   endtask
`endif

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = 3'd0;
      bus.rsp_ready  = 1'b0;
      bin_in         = '0;
      gray_in        = '0;
      bcd_in         = '0;
      force_done_low = 1'b0;
      test_reset();
      test_bin2gray();
      test_bin2bcd();
      test_bcd2bin_hold();
      test_illegal();
      test_reset_abort();
`ifdef CONV_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
